// File: rtl/prog_boot_ctrl_if.sv
// Host load channel and instruction-memory write port of the boot controller.
// The controller takes the slave side; the host/memory environment takes master.
interface prog_boot_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_boot_ctrl.sv
// Boot/run controller: streams a program into instruction memory with the CPU held in
// reset, then runs it until halt or cycle budget. Define BOOT_CHECKSUM_EN to add o_load_sum.
module prog_boot_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    parameter int RST_HOLD   = 2,
    parameter int RUN_CYCLES = 30
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    prog_boot_ctrl_if.slave   io_bus,
    output logic              o_cpu_rstn,
    output logic              o_cpu_en,
    input  logic [ADDR_W-1:0] i_cpu_pc,
    input  logic [ADDR_W-1:0] i_halt_addr,
    output logic [ADDR_W:0]   o_load_count,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_load_err
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] o_load_sum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    localparam int                HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(RUN_CYCLES - 1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_load_count;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_done, r_timeout, r_load_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_xfer, w_load_enter, w_halt, w_budget;
    logic w_ld_ready, w_cpu_rstn, w_cpu_en;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        w_load_enter = 1'b0;
        w_halt       = 1'b0;
        w_budget     = 1'b0;
        w_ld_ready   = 1'b0;
        w_cpu_rstn   = 1'b0;
        w_cpu_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_LOAD;
                    w_load_enter = 1'b1;
                end
            end
            S_LOAD: begin
                w_ld_ready = 1'b1;
                w_xfer     = io_bus.ld_valid;
                // The last address ends the load even without ld_last: the pointer never wraps.
                if (w_xfer && (io_bus.ld_last || (r_ptr == PTR_MAX)))
                    w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_cpu_rstn = 1'b1;
                w_cpu_en   = 1'b1;
                w_halt     = (i_cpu_pc == i_halt_addr);
                w_budget   = (RUN_CYCLES != 0) && (r_cycle_count == BUDGET_LAST);
                if (w_halt || w_budget) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_cpu_rstn = 1'b1;
                if (i_start) begin
                    w_state_next = S_LOAD;
                    w_load_enter = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr         <= '0;
            r_load_count  <= '0;
            r_cycle_count <= '0;
            r_hold_cnt    <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_load_err    <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_mem_we <= w_xfer;
            if (w_load_enter) begin
                r_ptr         <= '0;
                r_load_count  <= '0;
                r_cycle_count <= '0;
                r_done        <= 1'b0;
                r_timeout     <= 1'b0;
                r_load_err    <= 1'b0;
            end
            if (w_xfer) begin
                r_mem_addr   <= r_ptr;
                r_mem_wdata  <= io_bus.ld_data;
                r_load_count <= r_load_count + 1'b1;
                if (r_ptr != PTR_MAX)     r_ptr      <= r_ptr + 1'b1;
                else if (!io_bus.ld_last) r_load_err <= 1'b1;
            end
            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
            else                   r_hold_cnt <= '0;
            // The exit cycle keeps its count, so cycle_count reads RUN cycles minus one.
            if (r_state == S_RUN) begin
                if (w_halt || w_budget) begin
                    r_done    <= 1'b1;
                    r_timeout <= !w_halt;
                end else if (r_cycle_count != CNT_MAX) begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                end
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] r_load_sum;

    always_ff @(posedge clk) begin
        if (!rstn)             r_load_sum <= '0;
        else if (w_load_enter) r_load_sum <= '0;
        else if (w_xfer)       r_load_sum <= r_load_sum + io_bus.ld_data;
    end

    assign o_load_sum = r_load_sum;
`endif

    assign io_bus.ld_ready  = w_ld_ready;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign o_cpu_rstn       = w_cpu_rstn;
    assign o_cpu_en         = w_cpu_en;
    assign o_load_count     = r_load_count;
    assign o_cycle_count    = r_cycle_count;
    assign o_done           = r_done;
    assign o_timeout        = r_timeout;
    assign o_load_err       = r_load_err;

endmodule

// File: tb/tb_prog_boot_ctrl.sv
// Self-checking bench for prog_boot_ctrl: directed test-plan scenarios plus randomized
// loads/runs checked against an arithmetic model of load and run outcomes.
`timescale 1ns/1ps
module tb_prog_boot_ctrl;
    localparam int DW = 8, AW = 8, CW = 16, HOLD = 2, BUDGET = 30, AW4 = 4;
    localparam logic [7:0] PROG [16] = '{8'h88, 8'h89, 8'h24, 8'h39, 8'h49, 8'h58, 8'h62, 8'h64,
                                         8'h68, 8'h81, 8'h89, 8'h6C, 8'h8E, 8'h71, 8'h89, 8'h75};

    logic clk = 1'b0;
    logic rstn, start, start4;
    logic [AW-1:0]  halt_addr, cpu_pc;
    logic [15:0]    cpu_acc;
    logic           cpu_rstn, cpu_en, done, timeout, load_err;
    logic [AW:0]    load_count;
    logic [CW-1:0]  cycle_count;
    logic [AW4-1:0] pc4, halt4;
    logic           cpu_rstn4, cpu_en4, done4, timeout4, load_err4;
    logic [AW4:0]   load_count4;
    logic [CW-1:0]  cycle_count4;
`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0]  load_sum, load_sum4;
`endif

    int n_pass = 0, n_checks = 0;
    logic [7:0]  stim_q[$];
    logic [15:0] wr_q[$];
    logic [11:0] wr4_q[$];

    always #5 clk = ~clk;

    prog_boot_ctrl_if #(.DATA_W(DW), .ADDR_W(AW))  bus ();
    prog_boot_ctrl_if #(.DATA_W(DW), .ADDR_W(AW4)) bus4 ();

    prog_boot_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RST_HOLD(HOLD), .RUN_CYCLES(BUDGET)) dut (
        .clk(clk), .rstn(rstn), .i_start(start), .io_bus(bus),
        .o_cpu_rstn(cpu_rstn), .o_cpu_en(cpu_en), .i_cpu_pc(cpu_pc), .i_halt_addr(halt_addr),
        .o_load_count(load_count), .o_cycle_count(cycle_count), .o_done(done),
        .o_timeout(timeout), .o_load_err(load_err)
`ifdef BOOT_CHECKSUM_EN
        , .o_load_sum(load_sum)
`endif
    );

    prog_boot_ctrl #(.DATA_W(DW), .ADDR_W(AW4), .CNT_W(CW), .RST_HOLD(HOLD), .RUN_CYCLES(BUDGET)) dut4 (
        .clk(clk), .rstn(rstn), .i_start(start4), .io_bus(bus4),
        .o_cpu_rstn(cpu_rstn4), .o_cpu_en(cpu_en4), .i_cpu_pc(pc4), .i_halt_addr(halt4),
        .o_load_count(load_count4), .o_cycle_count(cycle_count4), .o_done(done4),
        .o_timeout(timeout4), .o_load_err(load_err4)
`ifdef BOOT_CHECKSUM_EN
        , .o_load_sum(load_sum4)
`endif
    );

    // Toy CPU: PC advances once per enabled cycle, an accumulator stands in for register state.
    always @(posedge clk) begin
        if (!cpu_rstn) begin
            cpu_pc  <= '0;
            cpu_acc <= '0;
        end else if (cpu_en) begin
            cpu_pc  <= cpu_pc + 1'b1;
            cpu_acc <= cpu_acc + 16'(cpu_pc) + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_we)  wr_q.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus4.mem_we) wr4_q.push_back({bus4.mem_addr, bus4.mem_wdata});
    end

    // Reference: PC equals the RUN cycle index, so halt at cycle h unless the budget ends first.
    function automatic void run_model(input int h, output int cnt, output bit to, output int cyc);
        if (h < BUDGET) begin cnt = h; to = 1'b0; cyc = h + 1; end
        else            begin cnt = BUDGET - 1; to = 1'b1; cyc = BUDGET; end
    endfunction

    function automatic int write_errors();
        int bad;
        bad = (wr_q.size() != stim_q.size()) ? 1 : 0;
        foreach (stim_q[i])
            if (i >= wr_q.size() || wr_q[i] !== {AW'(i), stim_q[i]}) bad++;
        return bad;
    endfunction

    function automatic logic [7:0] model_sum();
        logic [7:0] s = '0;
        foreach (stim_q[i]) s = s + stim_q[i];
        return s;
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Presents stim_q with random valid gaps; returns at the negedge after the final transfer.
    task automatic send_bytes(input bit use_last, input int gap_pct, output bit ok);
        int i = 0;
        int guard = 0;
        bit v;
        while (i < stim_q.size() && guard < 1000) begin
            @(negedge clk); guard++;
            v = ($urandom_range(99) >= gap_pct);
            bus.ld_valid = v;
            bus.ld_data  = stim_q[i];
            bus.ld_last  = use_last && (i == stim_q.size() - 1);
            if (v && bus.ld_ready) i++;
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        ok = (i == stim_q.size());
    endtask

    task automatic wait_done(output int run_cyc, output bit ok);
        int guard = 0;
        run_cyc = 0;
        while (!done && guard < 2000) begin
            if (cpu_en) run_cyc++;
            @(negedge clk); guard++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        logic [47:0] snap;
        logic [39:0] snap4;
        rstn = 1'b0; start = 1'b0; start4 = 1'b0; halt_addr = '0; pc4 = '0; halt4 = '0;
        bus.ld_valid = 1'b0;  bus.ld_data = '0;  bus.ld_last = 1'b0;
        bus4.ld_valid = 1'b0; bus4.ld_data = '0; bus4.ld_last = 1'b0;
        repeat (2) @(negedge clk);
        snap = {bus.ld_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rstn, cpu_en,
                load_count, cycle_count, done, timeout, load_err};
        n_checks++; if (snap !== '0) $display("FAIL reset_outputs: got %h want 0", snap); else n_pass++;
        snap4 = {bus4.ld_ready, bus4.mem_we, bus4.mem_addr, bus4.mem_wdata, cpu_rstn4, cpu_en4,
                 load_count4, cycle_count4, done4, timeout4, load_err4};
        n_checks++; if (snap4 !== '0) $display("FAIL reset_outputs4: got %h want 0", snap4); else n_pass++;
`ifdef BOOT_CHECKSUM_EN
        n_checks++; if (load_sum !== '0) $display("FAIL reset_sum: got %h want 0", load_sum); else n_pass++;
`endif
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.ld_ready, cpu_rstn} !== 2'b00) $display("FAIL idle_outputs: got %b want 00", {bus.ld_ready, cpu_rstn}); else n_pass++;
        do_start();
        n_checks++; if (bus.ld_ready !== 1'b1) $display("FAIL start_ready: got %b want 1", bus.ld_ready); else n_pass++;
    endtask

    // Continues from the LOAD state left by test_reset.
    task automatic test_load_stream();
        bit ok; int hold_lo = 0; int rc, cnt, cyc; bit to;
        halt_addr = 8'h05;
        stim_q.delete(); wr_q.delete();
        foreach (PROG[i]) stim_q.push_back(PROG[i]);
        send_bytes(1'b1, 0, ok);
        n_checks++; if (!ok) $display("FAIL load_accepted: got 0 want 1"); else n_pass++;
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h0F, 8'h75})
            $display("FAIL last_write: got %h want 10f75", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); else n_pass++;
        while (!cpu_rstn && hold_lo < 20) begin hold_lo++; @(negedge clk); end
        n_checks++; if (hold_lo != HOLD) $display("FAIL hold_cycles: got %0d want %0d", hold_lo, HOLD); else n_pass++;
        wait_done(rc, ok);
        run_model(5, cnt, to, cyc);
        n_checks++; if (write_errors() != 0) $display("FAIL load_writes: got %0d bad want 0", write_errors()); else n_pass++;
        n_checks++; if (load_count !== 9'd16) $display("FAIL load_count: got %0d want 16", load_count); else n_pass++;
        n_checks++; if ({ok, timeout, load_err} !== {1'b1, to, 1'b0}) $display("FAIL load_run_flags: got %b want %b", {ok, timeout, load_err}, {1'b1, to, 1'b0}); else n_pass++;
        n_checks++; if (cycle_count !== CW'(cnt)) $display("FAIL load_run_count: got %0d want %0d", cycle_count, cnt); else n_pass++;
`ifdef BOOT_CHECKSUM_EN
        n_checks++; if (load_sum !== model_sum()) $display("FAIL load_sum: got %h want %h", load_sum, model_sum()); else n_pass++;
`endif
    endtask

    task automatic test_halt();
        bit ok; int rc; logic [AW-1:0] pc_s; logic [15:0] acc_s; logic [CW-1:0] cc_s;
        halt_addr = 8'h11;
        stim_q.delete(); wr_q.delete();
        foreach (PROG[i]) stim_q.push_back(PROG[i]);
        stim_q.push_back(8'h00); stim_q.push_back(8'h00);
        do_start();
        send_bytes(1'b1, 0, ok);
        wait_done(rc, ok);
        n_checks++; if (write_errors() != 0) $display("FAIL halt_writes: got %0d bad want 0", write_errors()); else n_pass++;
        n_checks++; if (load_count !== 9'd18) $display("FAIL halt_load_count: got %0d want 18", load_count); else n_pass++;
        n_checks++; if ({ok, timeout, cpu_en, cpu_rstn} !== 4'b1001) $display("FAIL halt_flags: got %b want 1001", {ok, timeout, cpu_en, cpu_rstn}); else n_pass++;
        n_checks++; if (cycle_count !== 16'd17) $display("FAIL halt_count: got %0d want 17", cycle_count); else n_pass++;
        n_checks++; if (rc != 18) $display("FAIL halt_run_cycles: got %0d want 18", rc); else n_pass++;
        pc_s = cpu_pc; acc_s = cpu_acc; cc_s = cycle_count;
        repeat (4) @(negedge clk);
        n_checks++; if ({cpu_pc, cpu_acc, cycle_count, done} !== {pc_s, acc_s, cc_s, 1'b1})
            $display("FAIL halt_frozen: got %h want %h", {cpu_pc, cpu_acc, cycle_count, done}, {pc_s, acc_s, cc_s, 1'b1}); else n_pass++;
    endtask

    // Budget exhaustion, then halt landing on the budget's final cycle (halt wins).
    task automatic test_timeout();
        bit ok, to; int rc, cnt, cyc;
        int hs [2] = '{255, BUDGET - 1};
        foreach (hs[k]) begin
            halt_addr = AW'(hs[k]);
            stim_q.delete(); wr_q.delete();
            repeat (4) stim_q.push_back(8'($urandom));
            do_start();
            send_bytes(1'b1, 0, ok);
            wait_done(rc, ok);
            run_model(hs[k], cnt, to, cyc);
            n_checks++; if ({ok, timeout} !== {1'b1, to}) $display("FAIL timeout_flags h=%0d: got %b want %b", hs[k], {ok, timeout}, {1'b1, to}); else n_pass++;
            n_checks++; if (cycle_count !== CW'(cnt)) $display("FAIL timeout_count h=%0d: got %0d want %0d", hs[k], cycle_count, cnt); else n_pass++;
            n_checks++; if (rc != cyc) $display("FAIL timeout_run_cycles h=%0d: got %0d want %0d", hs[k], rc, cyc); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d [17];
        bit rdy_bad = 1'b0; logic rdy17, err17; int guard = 0; int bad = 0;
        wr4_q.delete();
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d[i] = 8'($urandom);
            @(negedge clk);
            if (i < 16 && !bus4.ld_ready) rdy_bad = 1'b1;
            if (i == 16) begin rdy17 = bus4.ld_ready; err17 = load_err4; end
            bus4.ld_valid = 1'b1; bus4.ld_data = d[i]; bus4.ld_last = 1'b0;
        end
        @(negedge clk); bus4.ld_valid = 1'b0;
        while (!done4 && guard < 200) begin guard++; @(negedge clk); end
        if (wr4_q.size() != 16) bad++;
        foreach (wr4_q[i]) if (i >= 16 || wr4_q[i] !== {AW4'(i), d[i]}) bad++;
        n_checks++; if (rdy_bad) $display("FAIL ovf_ready_stream: got stall want none"); else n_pass++;
        n_checks++; if ({rdy17, err17} !== 2'b01) $display("FAIL ovf_byte17: got ready/err %b want 01", {rdy17, err17}); else n_pass++;
        n_checks++; if (load_count4 !== 5'd16) $display("FAIL ovf_load_count: got %0d want 16", load_count4); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL ovf_writes: got %0d bad want 0", bad); else n_pass++;
        n_checks++; if ({done4, timeout4, load_err4} !== 3'b101) $display("FAIL ovf_done: got %b want 101", {done4, timeout4, load_err4}); else n_pass++;
    endtask

    task automatic test_reset_midload();
        bit ok; int rc; int rb = 0; int guard = 0;
        logic [47:0] snap;
        stim_q.delete(); wr_q.delete();
        repeat (5) stim_q.push_back(8'($urandom));
        do_start();
        send_bytes(1'b0, 0, ok);
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        snap = {bus.ld_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rstn, cpu_en,
                load_count, cycle_count, done, timeout, load_err};
        n_checks++; if (snap !== '0) $display("FAIL midload_reset: got %h want 0", snap); else n_pass++;
        halt_addr = 8'd12;
        stim_q.delete(); wr_q.delete();
        repeat (3) stim_q.push_back(8'($urandom));
        do_start();
        send_bytes(1'b1, 0, ok);
        while (!cpu_en && guard < 50) begin guard++; @(negedge clk); end
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            @(negedge clk);
            if (bus.ld_ready) rb++;
        end
        start = 1'b0;
        wait_done(rc, ok);
        n_checks++; if (rb != 0) $display("FAIL run_start_ignored: got %0d ready cycles want 0", rb); else n_pass++;
        n_checks++; if (load_count !== 9'd3) $display("FAIL reload_count: got %0d want 3", load_count); else n_pass++;
        n_checks++; if (write_errors() != 0) $display("FAIL reload_writes: got %0d bad want 0", write_errors()); else n_pass++;
        n_checks++; if ({ok, timeout, cycle_count} !== {2'b10, 16'd12}) $display("FAIL reload_run: got %h want %h", {ok, timeout, cycle_count}, {2'b10, 16'd12}); else n_pass++;
    endtask

    task automatic test_random();
        bit ok, lok, to; int rc, cnt, cyc, n, h, gap;
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(1, 40);
            gap = $urandom_range(0, 50);
            h   = ($urandom_range(3) == 0) ? 255 : $urandom_range(0, 34);
            halt_addr = AW'(h);
            stim_q.delete(); wr_q.delete();
            repeat (n) stim_q.push_back(8'($urandom));
            do_start();
            send_bytes(1'b1, gap, lok);
            wait_done(rc, ok);
            run_model(h, cnt, to, cyc);
            n_checks++; if (write_errors() != 0 || !lok) $display("FAIL rand%0d_writes: got %0d bad want 0", it, write_errors()); else n_pass++;
            n_checks++; if (load_count !== 9'(n)) $display("FAIL rand%0d_load_count: got %0d want %0d", it, load_count, n); else n_pass++;
            n_checks++; if ({ok, timeout, cycle_count} !== {1'b1, to, CW'(cnt)})
                $display("FAIL rand%0d_run: got %h want %h", it, {ok, timeout, cycle_count}, {1'b1, to, CW'(cnt)}); else n_pass++;
            n_checks++; if (rc != cyc) $display("FAIL rand%0d_run_cycles: got %0d want %0d", it, rc, cyc); else n_pass++;
`ifdef BOOT_CHECKSUM_EN
            n_checks++; if (load_sum !== model_sum()) $display("FAIL rand%0d_sum: got %h want %h", it, load_sum, model_sum()); else n_pass++;
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_stream();
        test_halt();
        test_timeout();
        test_overflow();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
